// File: rtl/uart_tx_fifo_if.sv
// CPU-side write port and serial/status outputs of the UART transmitter.
interface uart_tx_fifo_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       tx_empty;
  logic       tx_idle;
  logic       tx_done_tick;
  logic [7:0] tx_fifo_out;
  logic       tx;

  modport master (
    output wr_en, wr_data,
    input  full, tx_empty, tx_idle, tx_done_tick, tx_fifo_out, tx
  );

  modport slave (
    input  wr_en, wr_data,
    output full, tx_empty, tx_idle, tx_done_tick, tx_fifo_out, tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO feeding an 8N1 LSB-first serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 64,
  parameter int unsigned FIFO_AW      = 2
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [CW-1:0]    BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_nxt;
  logic [CW-1:0]      baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  state_t             state;

  logic       tx_q;
  logic       full_q;
  logic       empty_q;
  logic       idle_q;
  logic       done_q;
  logic [7:0] out_q;

  logic push_c;
  logic pop_c;
  logic baud_end_c;
  logic line_c;

  // Full is judged on the registered count, so a write colliding with a pop on a full FIFO is dropped.
  always_comb begin
    push_c     = bus.wr_en && (count != FULL_CNT);
    pop_c      = (state == S_IDLE) && (count != '0);
    baud_end_c = (baud == BAUD_LAST);
    count_nxt  = count + (FIFO_AW + 1)'(push_c) - (FIFO_AW + 1)'(pop_c);
    line_c     = 1'b1;
    case (state)
      S_START:    line_c = 1'b0;
      S_DATA:     line_c = shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY:   line_c = ^out_q;
`endif
      default:    line_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= bus.wr_data;
  end

  // tx and tx_idle trail the state by one clock, giving the IDLE visit as one high bit-gap clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      state   <= S_IDLE;
      tx_q    <= 1'b1;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      tx_q    <= line_c;
      count   <= count_nxt;
      full_q  <= (count_nxt == FULL_CNT);
      empty_q <= (count_nxt == '0);
      idle_q  <= (state == S_IDLE) && !pop_c && (count_nxt == '0);
      if (push_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + FIFO_AW'(1);

      case (state)
        S_IDLE: begin
          baud    <= '0;
          bit_idx <= '0;
          if (pop_c) begin
            shift <= mem[rd_ptr];
            out_q <= mem[rd_ptr];
            state <= S_START;
          end
        end
        S_START: begin
          if (baud_end_c) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            baud <= baud + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_end_c) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end_c) begin
            baud  <= '0;
            state <= S_STOP;
          end else begin
            baud <= baud + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_end_c) begin
            baud   <= '0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            baud <= baud + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx           = tx_q;
  assign bus.full         = full_q;
  assign bus.tx_empty     = empty_q;
  assign bus.tx_idle      = idle_q;
  assign bus.tx_done_tick = done_q;
  assign bus.tx_fifo_out  = out_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: occupancy/timing model plus a serial-line receiver feeding a scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int CPB   = 64;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #31.25 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: FIFO occupancy, pop times and the expected order of bytes on the line.
  logic [7:0] q[$];
  int mcount, mcyc, idle_from;
  bit m_acc, m_pop;
  initial begin
    mcount = 0; mcyc = 0; idle_from = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mcount = 0; mcyc = 0; idle_from = 0;
        q.delete();
      end else begin
        m_acc = bus.wr_en && (mcount < DEPTH);
        m_pop = (mcount > 0) && (mcyc >= idle_from);
        if (m_acc) q.push_back(bus.wr_data);
        if (m_pop) idle_from = mcyc + FRAME + 1;
        mcount = mcount + int'(m_acc) - int'(m_pop);
        mcyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("full", 32'(bus.full), 32'(mcount == DEPTH));
        check("tx_empty", 32'(bus.tx_empty), 32'(mcount == 0));
      end
    end
  end

  // Serial receiver: frame starts on a falling edge, bits sampled mid-bit.
  bit rx_active = 0, prev_tx = 1, pend_idle = 0, idle_at_end = 0, idle_after_end = 0;
  int off = 0, frames_done = 0;
  logic [NBITS-1:0] bits;
  logic [7:0] exp_b, rx_b;
  int start_at[$];
  logic [7:0] cap[$];

  task automatic end_frame();
    rx_b = bits[8:1];
    check("start_bit", 32'(bits[0]), 32'(0));
    check("stop_bit", 32'(bits[NBITS-1]), 32'(1));
    check("done_tick_pos", 32'(bus.tx_done_tick), 32'(1));
    if (q.size() == 0) begin
      check("frame_without_write", 32'(rx_b), 32'hFFFF_FFFF);
    end else begin
      exp_b = q.pop_front();
      check("rx_byte", 32'(rx_b), 32'(exp_b));
      check("fifo_out", 32'(bus.tx_fifo_out), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
      check("parity_bit", 32'(bits[9]), 32'(^exp_b));
`endif
    end
    cap.push_back(bus.tx_fifo_out);
    idle_at_end = bus.tx_idle;
    pend_idle   = 1;
    frames_done++;
    rx_active   = 0;
  endtask

  initial begin
    bits = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_active = 0; prev_tx = 1; pend_idle = 0;
      end else begin
        if (pend_idle) begin
          idle_after_end = bus.tx_idle;
          pend_idle = 0;
        end
        if (!rx_active) begin
          if (bus.tx_done_tick) check("stray_tick", 32'(1), 32'(0));
          if (prev_tx && !bus.tx) begin
            rx_active = 1; off = 0;
            start_at.push_back(cyc);
          end
        end
        if (rx_active) begin
          if (off % CPB == CPB / 2) bits[off / CPB] = bus.tx;
          // The tick occupies the last clock of the stop bit: clock FRAME of the frame, offset FRAME-1.
          if (off == FRAME - 1) end_frame();
          else if (bus.tx_done_tick) check("early_tick", 32'(off), 32'(FRAME - 1));
          off++;
        end
        prev_tx = bus.tx;
      end
    end
  end

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 8 * FRAME && frames_done < target; i++) @(negedge clk);
    if (frames_done < target) check("frame_timeout", 32'(frames_done), 32'(target));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int wc, nf, ns, fd_before;
  bit low_seen;
  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0;
    #100;
    check("rst_tx", 32'(bus.tx), 32'(1));
    check("rst_full", 32'(bus.full), 32'(0));
    check("rst_tx_empty", 32'(bus.tx_empty), 32'(1));
    check("rst_tx_idle", 32'(bus.tx_idle), 32'(1));
    check("rst_done_tick", 32'(bus.tx_done_tick), 32'(0));
    check("rst_fifo_out", 32'(bus.tx_fifo_out), 32'(0));
    #100 reset = 1'b0;
    @(negedge clk);

    // Single byte: latency from write edge to start bit.
    ns = start_at.size();
    push(8'h31); bus.wr_en = 1'b0;
    wc = cyc;
    wait_frames(1);
    check("start_latency", 32'(start_at[ns] - wc), 32'(2));

    // Back-to-back frames: one idle clock between them, tx_idle only after the second stop bit.
    repeat (10) @(negedge clk);
    nf = frames_done; ns = start_at.size();
    push(8'h31); push(8'h32); bus.wr_en = 1'b0;
    wait_frames(nf + 2);
    repeat (3) @(negedge clk);
    check("b2b_gap", 32'(start_at[ns+1] - start_at[ns]), 32'(FRAME + 1));
    check("cap_first", 32'(cap[nf]), 32'h31);
    check("cap_second", 32'(cap[nf+1]), 32'h32);
    check("idle_at_last_tick", 32'(idle_at_end), 32'(0));
    check("idle_after_stop", 32'(idle_after_end), 32'(1));
    $display("[TB] bytes captured on tx_done_tick: %c%c", cap[nf], cap[nf+1]);

    // Overflow: sixth consecutive write meets a full FIFO.
    repeat (10) @(negedge clk);
    nf = frames_done;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("full_before_A5", 32'(bus.full), 32'(1));
      push(8'hA0 + 8'(i));
    end
    bus.wr_en = 1'b0;
    wait_frames(nf + 5);
    repeat (FRAME + 100) @(negedge clk);
    check("overflow_frames", 32'(frames_done), 32'(nf + 5));
    for (int i = 0; i < 5; i++) check("overflow_order", 32'(cap[nf+i]), 32'(8'hA0 + 8'(i)));

    // Write on the exact cycle IDLE pops from a full FIFO.
    nf = frames_done;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    bus.wr_en = 1'b0;
    check("collision_full", 32'(bus.full), 32'(1));
    for (int i = 0; i < 2 * FRAME && !bus.tx_done_tick; i++) @(negedge clk);
    check("collision_tick_seen", 32'(bus.tx_done_tick), 32'(1));
    push(8'hEE); bus.wr_en = 1'b0;
    check("collision_full_after", 32'(bus.full), 32'(0));
    check("collision_empty_after", 32'(bus.tx_empty), 32'(0));
    wait_frames(nf + 5);
    repeat (FRAME + 100) @(negedge clk);
    check("collision_frames", 32'(frames_done), 32'(nf + 5));
    for (int i = 0; i < 5; i++) check("collision_order", 32'(cap[nf+i]), 32'(8'h10 + 8'(i)));

    // Reset during data bit 3 of 0x55 with two bytes queued.
    ns = start_at.size();
    push(8'h55); push(8'h66); push(8'h77); bus.wr_en = 1'b0;
    for (int i = 0; i < 2 * FRAME && start_at.size() == ns; i++) @(negedge clk);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("pre_reset_bit3", 32'(bus.tx), 32'(0));
    fd_before = frames_done;
    #5 reset = 1'b1;
    #1;
    check("midreset_tx", 32'(bus.tx), 32'(1));
    check("midreset_tx_empty", 32'(bus.tx_empty), 32'(1));
    check("midreset_tx_idle", 32'(bus.tx_idle), 32'(1));
    check("midreset_full", 32'(bus.full), 32'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    low_seen = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (!bus.tx || bus.tx_done_tick) low_seen = 1;
    end
    check("line_quiet_after_reset", 32'(low_seen), 32'(0));
    check("no_frame_after_reset", 32'(frames_done), 32'(fd_before));

`ifdef UART_TX_PARITY_EN
    nf = frames_done;
    push(8'h07); bus.wr_en = 1'b0;
    wait_frames(nf + 1);
    check("parity_07", 32'(bits[9]), 32'(1));
`endif

    // Random bursts with random gaps; drops and order come from the model.
    for (int b = 0; b < 12; b++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int j = 0; j < n; j++) push(8'($urandom));
      bus.wr_en = 1'b0;
      repeat ($urandom_range(0, FRAME)) @(negedge clk);
    end
    for (int i = 0; i < 12 * FRAME && (q.size() != 0 || mcount != 0 || rx_active); i++) @(negedge clk);
    check("drain_queue", 32'(q.size()), 32'(0));
    repeat (5) @(negedge clk);
    check("final_idle", 32'(bus.tx_idle), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
